mem_port_arbiter: RTL

Two-requester arbiter that shares one single-ported synchronous memory between the core's instruction-fetch port and its data port, so that `InstructionMemory` and `DataMemory` can be merged into one unified RAM. It sits between `Riscv` (fetch and load/store sides) and the memory. It grants one transaction at a time, waits a fixed read latency, and returns a one-cycle response pulse to the winner. Data accesses have priority; an anti-starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-ported synchronous memory between
// instruction fetch and data access. Data has priority; a saturating
// starvation counter forces a fetch win after STARVE_LIMIT contested data wins.
module mem_port_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_write,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 3;
  localparam int unsigned SW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t         state, state_d;
  logic           owner, owner_d;
  logic [LW-1:0]  lat_cnt, lat_cnt_d;
  logic [SW-1:0]  starve_cnt, starve_cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           store_q, store_d;

  logic           contested;
  logic           grant_d;
  logic           grant_f;

  // Winner selection: data first unless fetch has been starved to the limit
  always_comb begin
    contested = if_req_valid && d_req_valid;
    grant_d   = d_req_valid && !(contested && (starve_cnt == SW'(STARVE_LIMIT)));
    grant_f   = if_req_valid && !grant_d;
  end

  // Next-state, grant and response generation
  always_comb begin
    state_d       = state;
    owner_d       = owner;
    lat_cnt_d     = lat_cnt;
    starve_cnt_d  = starve_cnt;
    addr_d        = addr_q;
    store_d       = store_q;
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    if_resp_valid = 1'b0;
    d_resp_valid  = 1'b0;
    if_resp_data  = '0;
    d_resp_data   = '0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = addr_q;
    mem_wdata     = '0;

    unique case (state)
      IDLE: begin
        // Readies stay low while reset is held so no handshake can complete
        if (reset) begin
          if (grant_d) begin
            d_req_ready = 1'b1;
            mem_en      = 1'b1;
            mem_we      = d_req_write;
            mem_addr    = d_req_addr;
            mem_wdata   = d_req_wdata;
            state_d     = WAIT;
            owner_d     = 1'b1;
            addr_d      = d_req_addr;
            store_d     = d_req_write;
            lat_cnt_d   = LW'(READ_LATENCY);
            if (contested && (starve_cnt < SW'(STARVE_LIMIT))) begin
              starve_cnt_d = starve_cnt + SW'(1);
            end
          end else if (grant_f) begin
            if_req_ready = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = if_req_addr;
            state_d      = WAIT;
            owner_d      = 1'b0;
            addr_d       = if_req_addr;
            store_d      = 1'b0;
            lat_cnt_d    = LW'(READ_LATENCY);
            starve_cnt_d = '0;
          end
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt - LW'(1);
        if (lat_cnt == LW'(1)) begin
          state_d = IDLE;
          if (owner) begin
            d_resp_valid = 1'b1;
            d_resp_data  = store_q ? DW'(0) : mem_rdata;
          end else begin
            if_resp_valid = 1'b1;
            if_resp_data  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
      store_q    <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      lat_cnt    <= lat_cnt_d;
      starve_cnt <= starve_cnt_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
    end
  end

endmodule
